// File: rtl/modport_slice_arbiter_pkg.sv
// Shared types and constants for the modport slice arbiter.
// The optional contention counter is enabled by defining MODPORT_ARB_STATS_EN.
package modport_arb_pkg;

    typedef enum logic [1:0] {
        SEL_LO   = 2'b00,
        SEL_HI   = 2'b01,
        SEL_FULL = 2'b10,
        SEL_BAD  = 2'b11
    } slice_sel_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // Width helper that never returns 0, so one-entry ranges still get a real bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modport_slice_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after ptr (wrapping) wins.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             any
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/modport_slice_arbiter.sv
// Round-robin, lockable arbiter that is the sole writer of a shared lo/hi sliced register.
// Define MODPORT_ARB_STATS_EN to build the saturating contention counter on stat_conflict.
module modport_slice_arbiter
    import modport_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_sel,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         reg_q,
    output logic                      wr_flag,
    output logic                      err_sel,
    output logic [STAT_W-1:0]         stat_conflict
);

    localparam int PTR_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(LOCK_TIMEOUT);
    localparam int HALF  = DATA_W / 2;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shared_q, shared_d;
    logic              wr_flag_q, wr_flag_d;
    logic              err_sel_q, err_sel_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic               timeout;
    logic               xfer;
    logic [PTR_W-1:0]   win_idx;
    slice_sel_e         win_sel;
    logic [DATA_W-1:0]  win_data;
    logic               win_lock;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    assign timeout = (state_q == LOCKED) && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

    // Grants are withheld while reset is held so the outputs read as fully idle.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state_q == IDLE) begin
                if (pick_any) req_ready = pick_grant;
            end else if (!timeout && req_valid[owner_q]) begin
                req_ready[owner_q] = 1'b1;
            end
        end
    end

    always_comb begin
        xfer     = 1'b0;
        win_idx  = '0;
        win_sel  = SEL_LO;
        win_data = '0;
        win_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && req_valid[i]) begin
                xfer     = 1'b1;
                win_idx  = PTR_W'(i);
                win_sel  = slice_sel_e'(req_sel[2*i +: 2]);
                win_data = req_data[DATA_W*i +: DATA_W];
                win_lock = req_lock[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        shared_d  = shared_q;
        wr_flag_d = 1'b0;
        err_sel_d = 1'b0;

        if (xfer) begin
            ptr_d = win_idx;
            unique case (win_sel)
                SEL_LO:   shared_d[HALF-1:0]      = win_data[HALF-1:0];
                SEL_HI:   shared_d[DATA_W-1:HALF] = win_data[HALF-1:0];
                SEL_FULL: shared_d                = win_data;
                SEL_BAD:  shared_d                = shared_q;
            endcase
            wr_flag_d = (win_sel != SEL_BAD);
            err_sel_d = (win_sel == SEL_BAD);
        end

        // The lock ends on timeout, on the owner going idle, or on an unlocked owner transfer.
        unique case (state_q)
            IDLE: begin
                if (xfer && win_lock) begin
                    state_d = LOCKED;
                    owner_d = win_idx;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout || !req_valid[owner_q] || (xfer && !win_lock)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            shared_q  <= '0;
            wr_flag_q <= 1'b0;
            err_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            shared_q  <= shared_d;
            wr_flag_q <= wr_flag_d;
            err_sel_q <= err_sel_d;
        end
    end

    assign reg_q   = shared_q;
    assign wr_flag = wr_flag_q;
    assign err_sel = err_sel_q;

`ifdef MODPORT_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              conflict;

    always_comb begin
        conflict = |(req_valid & ~req_ready);
        stat_d   = stat_q;
        if (conflict && (stat_q != {STAT_W{1'b1}})) stat_d = stat_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign stat_conflict = stat_q;
`else
    assign stat_conflict = '0;
`endif

endmodule
